// File: rtl/toy_pack.sv
// Shared constants and pointer helpers for the physical register free list.
// Pointers carry a wrap bit so full and empty are distinguishable.
package toy_pack;

  localparam int PHY_REG_ID_WIDTH   = 7;
  localparam int ARCH_ENTRY_NUM     = 32;
  localparam int COMMIT_REL_CHANNEL = 4;
  localparam int RENAME_CHANNEL     = 4;
  localparam int FL_DEPTH           = 96;

  typedef struct packed {
    logic                        wrap;
    logic [PHY_REG_ID_WIDTH-1:0] idx;
  } fl_ptr_t;

  // Index arithmetic is modulo FL_DEPTH, which is not a power of two.
  function automatic fl_ptr_t ptr_add(fl_ptr_t p, logic [3:0] n);
    fl_ptr_t    r;
    logic [7:0] s;
    s = {1'b0, p.idx} + {4'b0, n};
    if (s >= 8'(FL_DEPTH)) begin
      r.idx  = 7'(s - 8'(FL_DEPTH));
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = s[6:0];
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  function automatic logic [7:0] ptr_diff(fl_ptr_t a, fl_ptr_t b);
    if (a.wrap == b.wrap)
      return {1'b0, a.idx} - {1'b0, b.idx};
    else
      return 8'(FL_DEPTH) + {1'b0, a.idx} - {1'b0, b.idx};
  endfunction

endpackage

// File: rtl/toy_freelist_compact.sv
// Prefix-rank compactor: each valid lane gets its rank among valid lanes
// below it, plus the total number of valid lanes.
module toy_freelist_compact #(
  parameter int N  = 7,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         v,
  output logic [N-1:0][CW-1:0] rank,
  output logic [CW-1:0]        total
);

  always_comb begin
    logic [CW-1:0] acc;
    acc  = '0;
    rank = '0;
    for (int i = 0; i < N; i++) begin
      rank[i] = acc;
      acc     = acc + {{(CW-1){1'b0}}, v[i]};
    end
    total = acc;
  end

endmodule

// File: rtl/toy_phy_freelist.sv
// Circular free list of physical register IDs with speculative and
// committed heads; a flush restores the speculative head in one cycle.
module toy_phy_freelist
  import toy_pack::PHY_REG_ID_WIDTH, toy_pack::fl_ptr_t,
         toy_pack::ptr_add, toy_pack::ptr_diff;
#(
  parameter int MODE           = 0,
  parameter int PHY_REG_NUM    = 128,
  parameter int ARCH_ENTRY_NUM = toy_pack::ARCH_ENTRY_NUM,
  parameter int FL_DEPTH       = PHY_REG_NUM - ARCH_ENTRY_NUM,
  parameter int REL_CH         = toy_pack::COMMIT_REL_CHANNEL,
  parameter int ALLOC_CH       = toy_pack::RENAME_CHANNEL
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REL_CH-1:0]                      v_phy_release_en,
  input  logic [REL_CH-1:0][PHY_REG_ID_WIDTH-1:0] v_phy_release_index,
  input  logic [REL_CH-2:0]                      v_phy_release_comb_en,
  input  logic [REL_CH-2:0][PHY_REG_ID_WIDTH-1:0] v_phy_release_comb_index,
  input  logic [ALLOC_CH-1:0]                    v_alloc_req,
  output logic                                   alloc_gnt,
  output logic [ALLOC_CH-1:0][PHY_REG_ID_WIDTH-1:0] v_alloc_phy_id,
  input  logic [2:0]                             commit_alloc_cnt,
  input  logic                                   flush,
  output logic [6:0]                             free_cnt
);

  localparam int W  = PHY_REG_ID_WIDTH;
  localparam int PL = 2 * REL_CH - 1;

  logic [W-1:0] arr [FL_DEPTH];
  fl_ptr_t      head_spec, head_cmt, tail;
  fl_ptr_t      spec_n, tail_n;
  fl_ptr_t      wr_ptr [PL];
  fl_ptr_t      rd_ptr [ALLOC_CH];

  logic [PL-1:0]          push_v;
  logic [PL-1:0][W-1:0]   push_id;
  logic [PL-1:0][2:0]     push_rank;
  logic [2:0]             push_total;
  logic [ALLOC_CH-1:0][2:0] pop_rank;
  logic [2:0]             pop_total;
  logic [2:0]             pop_n;

  assign push_v = {v_phy_release_comb_en, v_phy_release_en};

  always_comb begin
    push_id = '0;
    for (int i = 0; i < REL_CH; i++)
      push_id[i] = v_phy_release_index[i];
    for (int i = 0; i < REL_CH - 1; i++)
      push_id[REL_CH+i] = v_phy_release_comb_index[i];
  end

  toy_freelist_compact #(.N(PL), .CW(3)) u_push (
    .v     (push_v),
    .rank  (push_rank),
    .total (push_total)
  );

  toy_freelist_compact #(.N(ALLOC_CH), .CW(3)) u_pop (
    .v     (v_alloc_req),
    .rank  (pop_rank),
    .total (pop_total)
  );

  assign alloc_gnt = (free_cnt >= 7'(pop_total)) & ~flush & ~rst;
  assign pop_n     = alloc_gnt ? pop_total : 3'd0;

  always_comb begin
    for (int i = 0; i < PL; i++)
      wr_ptr[i] = ptr_add(tail, {1'b0, push_rank[i]});
    for (int k = 0; k < ALLOC_CH; k++)
      rd_ptr[k] = ptr_add(head_spec, {1'b0, pop_rank[k]});
  end

  always_comb begin
    v_alloc_phy_id = '0;
    for (int k = 0; k < ALLOC_CH; k++) begin
      if (rst)
        v_alloc_phy_id[k] = '0;
      else if (v_alloc_req[k])
        v_alloc_phy_id[k] = arr[rd_ptr[k].idx];
      else
        v_alloc_phy_id[k] = arr[head_spec.idx];
    end
  end

  // Flush rewinds to the committed head including this cycle's retirements.
  assign spec_n = flush ? ptr_add(head_cmt, {1'b0, commit_alloc_cnt})
                        : ptr_add(head_spec, {1'b0, pop_n});
  assign tail_n = ptr_add(tail, {1'b0, push_total});

  always_ff @(posedge clk) begin
    if (rst) begin
      head_spec <= '0;
      head_cmt  <= '0;
      tail      <= '{wrap: 1'b1, idx: '0};
      free_cnt  <= 7'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++)
        arr[i] <= W'(ARCH_ENTRY_NUM + i);
    end else begin
      head_spec <= spec_n;
      head_cmt  <= ptr_add(head_cmt, {1'b0, commit_alloc_cnt});
      tail      <= tail_n;
      free_cnt  <= 7'(ptr_diff(tail_n, spec_n));
      for (int i = 0; i < PL; i++)
        if (push_v[i])
          arr[wr_ptr[i].idx] <= push_id[i];
    end
  end

  a_cmt_le_spec: assert property (@(posedge clk) disable iff (rst)
    ptr_diff(head_spec, head_cmt) <= 8'(FL_DEPTH))
    else $error("freelist mode %0d: committed head passed speculative head", MODE);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    ptr_diff(tail_n, spec_n) <= 8'(FL_DEPTH))
    else $error("freelist mode %0d: overflow", MODE);

endmodule

// File: tb/tb_toy_phy_freelist.sv
// Scoreboard bench for toy_phy_freelist: an absolute-count model predicts
// grants and IDs, which are queued and compared against the design.
module tb_toy_phy_freelist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0]      rel_en;
  logic [3:0][6:0] rel_idx;
  logic [2:0]      comb_en;
  logic [2:0][6:0] comb_idx;
  logic [3:0]      req;
  logic            gnt;
  logic [3:0][6:0] ids;
  logic [2:0]      cc;
  logic            flush;
  logic [6:0]      free_cnt;

  toy_phy_freelist dut (
    .clk                      (clk),
    .rst                      (rst),
    .v_phy_release_en         (rel_en),
    .v_phy_release_index      (rel_idx),
    .v_phy_release_comb_en    (comb_en),
    .v_phy_release_comb_index (comb_idx),
    .v_alloc_req              (req),
    .alloc_gnt                (gnt),
    .v_alloc_phy_id           (ids),
    .commit_alloc_cnt         (cc),
    .flush                    (flush),
    .free_cnt                 (free_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] marr [96];
  int hs, hc, tl;
  int owned[$];
  int sb[$];
  logic e_gnt;

  function automatic int popc(logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic idle();
    req = '0; rel_en = '0; rel_idx = '0;
    comb_en = '0; comb_idx = '0; cc = '0; flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 96; i++) marr[i] = 7'(32 + i);
    hs = 0; hc = 0; tl = 96;
    owned.delete();
  endtask

  // Predict this cycle's grant and queue the expected IDs.
  task automatic look();
    int r;
    @(negedge clk);
    e_gnt = !rst && !flush && (tl - hs >= popc(req));
    sb.delete();
    r = 0;
    if (e_gnt)
      for (int k = 0; k < 4; k++)
        if (req[k]) begin
          sb.push_back(k * 256 + int'(marr[(hs + r) % 96]));
          r++;
        end
  endtask

  task automatic step();
    int r, sp;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (flush) begin
        sp = hc + int'(cc);
        for (int i = 0; i < hs - sp; i++) void'(owned.pop_back());
        hs = sp;
      end else if (e_gnt) begin
        for (int k = 0; k < 4; k++)
          if (req[k]) begin
            owned.push_back(int'(marr[hs % 96]));
            hs++;
          end
      end
      r = 0;
      for (int i = 0; i < 7; i++) begin
        if (i < 4 ? rel_en[i] : comb_en[i-4]) begin
          marr[(tl + r) % 96] = (i < 4) ? rel_idx[i] : comb_idx[i-4];
          r++;
        end
      end
      tl += r;
      hc += int'(cc);
    end
    #1;
  endtask

  task automatic rel_from_owned(int n);
    int id;
    rel_en = '0; comb_en = '0;
    for (int j = 0; j < n; j++) begin
      id = owned.pop_front();
      if (j < 4) begin rel_en[j] = 1'b1; rel_idx[j] = 7'(id); end
      else begin comb_en[j-4] = 1'b1; comb_idx[j-4] = 7'(id); end
    end
  endtask

  task automatic drop(int id);
    for (int i = 0; i < owned.size(); i++)
      if (owned[i] == id) begin owned.delete(i); break; end
  endtask

  task automatic commit_all();
    while (hs > hc) begin
      idle();
      cc = 3'((hs - hc >= 4) ? 4 : hs - hc);
      look();
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    look();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    checks++;
    if (ids !== '0) begin errors++; $display("FAIL reset_ids: got %h expected 0", ids); end
    step();
    rst = 1'b0;
    look();
    checks++;
    if (free_cnt !== 7'd96) begin errors++; $display("FAIL reset_free: got %0d expected 96", free_cnt); end
    step();
  endtask

  task automatic test_alloc4();
    req = 4'b1111;
    look();
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL alloc4_gnt: got %b expected 1", gnt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ids[k] !== 7'(32 + k)) begin errors++; $display("FAIL alloc4_id%0d: got %0d expected %0d", k, ids[k], 32 + k); end
    end
    step();
    idle();
    look();
    checks++;
    if (free_cnt !== 7'd92) begin errors++; $display("FAIL alloc4_free: got %0d expected 92", free_cnt); end
    step();
  endtask

  task automatic test_empty();
    int f, e;
    while (tl - hs > 2) begin
      f = tl - hs - 2;
      req = (f >= 4) ? 4'hf : 4'((1 << f) - 1);
      look();
      checks++;
      if (gnt !== e_gnt) begin errors++; $display("FAIL drain_gnt: got %b expected %b", gnt, e_gnt); end
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (ids[e/256] !== 7'(e % 256)) begin errors++; $display("FAIL drain_id lane %0d: got %0d expected %0d", e/256, ids[e/256], e % 256); end
      end
      step();
    end
    req = 4'b0111;
    look();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL short_gnt: got %b expected 0", gnt); end
    step();
    look();
    checks++;
    if (free_cnt !== 7'd2) begin errors++; $display("FAIL short_free: got %0d expected 2", free_cnt); end
    checks++;
    if (ids[0] !== 7'd126) begin errors++; $display("FAIL short_head: got %0d expected 126", ids[0]); end
    step();
    req = 4'b0101;
    look();
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL sparse_gnt: got %b expected 1", gnt); end
    checks++;
    if (ids[0] !== 7'd126) begin errors++; $display("FAIL sparse_id0: got %0d expected 126", ids[0]); end
    checks++;
    if (ids[2] !== 7'd127) begin errors++; $display("FAIL sparse_id2: got %0d expected 127", ids[2]); end
    step();
    idle();
    look();
    checks++;
    if (free_cnt !== 7'd0) begin errors++; $display("FAIL empty_free: got %0d expected 0", free_cnt); end
    step();
  endtask

  task automatic test_push_empty();
    drop(40); drop(41); drop(50);
    idle();
    rel_en = 4'b1010; rel_idx[1] = 7'd40; rel_idx[3] = 7'd41;
    comb_en = 3'b001; comb_idx[0] = 7'd50;
    req = 4'b0001;
    look();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL bypass_gnt: got %b expected 0", gnt); end
    step();
    idle();
    req = 4'b0111;
    look();
    checks++;
    if (free_cnt !== 7'd3) begin errors++; $display("FAIL push_free: got %0d expected 3", free_cnt); end
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL push_gnt: got %b expected 1", gnt); end
    checks++;
    if (ids[2:0] !== {7'd50, 7'd41, 7'd40}) begin errors++; $display("FAIL push_order: got %0d,%0d,%0d expected 40,41,50", ids[0], ids[1], ids[2]); end
    step();
    commit_all();
  endtask

  task automatic test_flush();
    int e, keep;
    idle();
    while (owned.size() > 0) begin
      rel_from_owned(owned.size() >= 7 ? 7 : owned.size());
      look();
      step();
    end
    idle();
    look();
    checks++;
    if (free_cnt !== 7'd96) begin errors++; $display("FAIL refill_free: got %0d expected 96", free_cnt); end
    step();
    keep = -1;
    for (int c = 0; c < 2; c++) begin
      req = 4'b1111;
      look();
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (c == 0 && e / 256 == 3) keep = e % 256;
        if (ids[e/256] !== 7'(e % 256)) begin errors++; $display("FAIL spec_id lane %0d: got %0d expected %0d", e/256, ids[e/256], e % 256); end
      end
      step();
    end
    flush = 1'b1; cc = 3'd3;
    look();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL flush_gnt: got %b expected 0", gnt); end
    step();
    idle();
    req = 4'b0001;
    look();
    checks++;
    if (free_cnt !== 7'd93) begin errors++; $display("FAIL flush_free: got %0d expected 93", free_cnt); end
    checks++;
    if (int'(ids[0]) !== keep) begin errors++; $display("FAIL flush_head: got %0d expected %0d", ids[0], keep); end
    step();
    commit_all();
  endtask

  task automatic test_wrap();
    int e, np, avail;
    for (int c = 0; c < 80; c++) begin
      idle();
      cc = 3'((hs - hc >= 4) ? 4 : hs - hc);
      avail = owned.size() - (hs - hc);
      np = $urandom_range(0, 7);
      if (np > avail) np = avail;
      rel_from_owned(np);
      req = 4'($urandom_range(0, 15));
      look();
      checks++;
      if (gnt !== e_gnt) begin errors++; $display("FAIL wrap_gnt: got %b expected %b", gnt, e_gnt); end
      checks++;
      if (free_cnt !== 7'(tl - hs)) begin errors++; $display("FAIL wrap_free: got %0d expected %0d", free_cnt, tl - hs); end
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (ids[e/256] !== 7'(e % 256)) begin errors++; $display("FAIL wrap_id lane %0d: got %0d expected %0d", e/256, ids[e/256], e % 256); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    req = 4'b1111;
    rst = 1'b1;
    look();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got %b expected 0", gnt); end
    step();
    rst = 1'b0;
    look();
    checks++;
    if (free_cnt !== 7'd96) begin errors++; $display("FAIL midrst_free: got %0d expected 96", free_cnt); end
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt2: got %b expected 1", gnt); end
    checks++;
    if (ids[0] !== 7'd32) begin errors++; $display("FAIL midrst_id: got %0d expected 32", ids[0]); end
    step();
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_alloc4();
    test_empty();
    commit_all();
    test_push_empty();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
